// File: rtl/axi4_lite_arbiter.sv
// ---------------------------------------------------------------------------
// axi4_lite_arbiter
//
// Purpose:
//   Shares one AXI4-Lite master port between two simple command/response
//   requesters. Only one transaction is in flight at a time. When both
//   requesters offer a command in the same cycle, they are granted in
//   round-robin order. The FSM walks IDLE -> (WR_REQ -> WR_RESP |
//   RD_ADDR -> RD_DATA) -> DONE -> IDLE. There is no timeout: a slave that
//   never answers keeps the FSM parked in the waiting state.
//
// Ports:
//   ACLK, ARESET           clock, synchronous active-high reset
//   CMDn_VALID/READY       command handshake; READY is a one-cycle grant pulse
//   CMDn_WRITE             1 = write, 0 = read
//   CMDn_ADDR/WDATA/WSTRB  command payload
//   RSPn_VALID             one-cycle completion pulse for requester n
//   RSPn_RDATA/RESP        last completion result for requester n
//                          (held until that requester's next completion)
//   AW*/W*/B*/AR*/R*       AXI4-Lite master channels
// ---------------------------------------------------------------------------
module axi4_lite_arbiter #(
  parameter int ADDRESS    = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESET,

  // Requester 0
  input  logic                    CMD0_VALID,
  output logic                    CMD0_READY,
  input  logic                    CMD0_WRITE,
  input  logic [ADDRESS-1:0]      CMD0_ADDR,
  input  logic [DATA_WIDTH-1:0]   CMD0_WDATA,
  input  logic [DATA_WIDTH/8-1:0] CMD0_WSTRB,
  output logic                    RSP0_VALID,
  output logic [DATA_WIDTH-1:0]   RSP0_RDATA,
  output logic [1:0]              RSP0_RESP,

  // Requester 1
  input  logic                    CMD1_VALID,
  output logic                    CMD1_READY,
  input  logic                    CMD1_WRITE,
  input  logic [ADDRESS-1:0]      CMD1_ADDR,
  input  logic [DATA_WIDTH-1:0]   CMD1_WDATA,
  input  logic [DATA_WIDTH/8-1:0] CMD1_WSTRB,
  output logic                    RSP1_VALID,
  output logic [DATA_WIDTH-1:0]   RSP1_RDATA,
  output logic [1:0]              RSP1_RESP,

  // AXI4-Lite write address channel
  output logic [ADDRESS-1:0]      AWADDR,
  output logic                    AWVALID,
  input  logic                    AWREADY,

  // AXI4-Lite write data channel
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WVALID,
  input  logic                    WREADY,

  // AXI4-Lite write response channel
  input  logic [1:0]              BRESP,
  input  logic                    BVALID,
  output logic                    BREADY,

  // AXI4-Lite read address channel
  output logic [ADDRESS-1:0]      ARADDR,
  output logic                    ARVALID,
  input  logic                    ARREADY,

  // AXI4-Lite read data channel
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]              RRESP,
  input  logic                    RVALID,
  output logic                    RREADY
);

  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Registered command
  logic                  r_write;
  logic [ADDRESS-1:0]    r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic                  r_grant;
  logic                  r_last;

  // Per-channel handshake completion inside WR_REQ
  logic                  r_aw_done;
  logic                  r_w_done;

  // Per-requester completion results
  logic [DATA_WIDTH-1:0] r_rsp0_rdata;
  logic [1:0]            r_rsp0_resp;
  logic [DATA_WIDTH-1:0] r_rsp1_rdata;
  logic [1:0]            r_rsp1_resp;

  // Combinational control
  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_grant_any;
  logic                  w_cmd0_ready;
  logic                  w_cmd1_ready;
  logic                  w_awvalid;
  logic                  w_wvalid;
  logic                  w_bready;
  logic                  w_arvalid;
  logic                  w_rready;
  logic                  w_rsp0_valid;
  logic                  w_rsp1_valid;
  logic                  w_capture;
  logic [DATA_WIDTH-1:0] w_cap_rdata;
  logic [1:0]            w_cap_resp;

  // Round-robin: a lone requester always wins; under contention the
  // requester that was not granted last wins. r_last resets to 1 so
  // requester 0 takes the first contention.
  assign w_gnt0      = CMD0_VALID && (!CMD1_VALID || r_last);
  assign w_gnt1      = CMD1_VALID && (!CMD0_VALID || !r_last);
  assign w_grant_any = w_gnt0 || w_gnt1;

  // A completion is captured on the response handshake of either path.
  // Writes report zero read data.
  assign w_capture   = ((r_state == WR_RESP) && BVALID) ||
                       ((r_state == RD_DATA) && RVALID);
  assign w_cap_rdata = r_write ? '0 : RDATA;
  assign w_cap_resp  = r_write ? BRESP : RRESP;

  // -------------------------------------------------------------------------
  // FSM: next-state and control outputs
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_cmd0_ready = 1'b0;
    w_cmd1_ready = 1'b0;
    w_awvalid    = 1'b0;
    w_wvalid     = 1'b0;
    w_bready     = 1'b0;
    w_arvalid    = 1'b0;
    w_rready     = 1'b0;
    w_rsp0_valid = 1'b0;
    w_rsp1_valid = 1'b0;

    case (r_state)
      IDLE: begin
        w_cmd0_ready = w_gnt0;
        w_cmd1_ready = w_gnt1;
        if (w_gnt0) begin
          w_state_nxt = CMD0_WRITE ? WR_REQ : RD_ADDR;
        end else if (w_gnt1) begin
          w_state_nxt = CMD1_WRITE ? WR_REQ : RD_ADDR;
        end
      end

      WR_REQ: begin
        // AW and W are independent: each drops after its own handshake.
        // Leave once both are done, including both in this same cycle.
        w_awvalid = !r_aw_done;
        w_wvalid  = !r_w_done;
        if ((r_aw_done || AWREADY) && (r_w_done || WREADY)) begin
          w_state_nxt = WR_RESP;
        end
      end

      WR_RESP: begin
        w_bready = 1'b1;
        if (BVALID) begin
          w_state_nxt = DONE;
        end
      end

      RD_ADDR: begin
        w_arvalid = 1'b1;
        if (ARREADY) begin
          w_state_nxt = RD_DATA;
        end
      end

      RD_DATA: begin
        w_rready = 1'b1;
        if (RVALID) begin
          w_state_nxt = DONE;
        end
      end

      DONE: begin
        w_rsp0_valid = !r_grant;
        w_rsp1_valid = r_grant;
        w_state_nxt  = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Command capture, grant bookkeeping and write handshake tracking
  // -------------------------------------------------------------------------
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_write   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_grant   <= 1'b0;
      r_last    <= 1'b1;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      if ((r_state == IDLE) && w_grant_any) begin
        r_grant   <= w_gnt1;
        r_last    <= w_gnt1;
        r_write   <= w_gnt1 ? CMD1_WRITE : CMD0_WRITE;
        r_addr    <= w_gnt1 ? CMD1_ADDR  : CMD0_ADDR;
        r_wdata   <= w_gnt1 ? CMD1_WDATA : CMD0_WDATA;
        r_wstrb   <= w_gnt1 ? CMD1_WSTRB : CMD0_WSTRB;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else if (r_state == WR_REQ) begin
        if (w_awvalid && AWREADY) begin
          r_aw_done <= 1'b1;
        end
        if (w_wvalid && WREADY) begin
          r_w_done <= 1'b1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Per-requester result registers. Loaded on the response handshake so the
  // values are already visible during the DONE pulse.
  // -------------------------------------------------------------------------
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_rsp0_rdata <= '0;
      r_rsp0_resp  <= '0;
      r_rsp1_rdata <= '0;
      r_rsp1_resp  <= '0;
    end else if (w_capture) begin
      if (r_grant) begin
        r_rsp1_rdata <= w_cap_rdata;
        r_rsp1_resp  <= w_cap_resp;
      end else begin
        r_rsp0_rdata <= w_cap_rdata;
        r_rsp0_resp  <= w_cap_resp;
      end
    end
  end

  // Requester-side outputs
  assign CMD0_READY = w_cmd0_ready;
  assign CMD1_READY = w_cmd1_ready;
  assign RSP0_VALID = w_rsp0_valid;
  assign RSP1_VALID = w_rsp1_valid;
  assign RSP0_RDATA = r_rsp0_rdata;
  assign RSP0_RESP  = r_rsp0_resp;
  assign RSP1_RDATA = r_rsp1_rdata;
  assign RSP1_RESP  = r_rsp1_resp;

  // AXI outputs. Address and data buses are zero whenever their VALID is
  // low and come from registered command fields, so they are stable for as
  // long as VALID is held.
  assign AWVALID = w_awvalid;
  assign AWADDR  = w_awvalid ? r_addr : '0;
  assign WVALID  = w_wvalid;
  assign WDATA   = w_wvalid ? r_wdata : '0;
  assign WSTRB   = w_wvalid ? r_wstrb : '0;
  assign BREADY  = w_bready;
  assign ARVALID = w_arvalid;
  assign ARADDR  = w_arvalid ? r_addr : '0;
  assign RREADY  = w_rready;

endmodule
